// File: rtl/i2s_frame_tx_pkg.sv
// rtl/i2s_frame_tx_pkg.sv - frame timing constants and sample pair type for the I2S transmitter
package i2s_frame_tx_pkg;

  localparam int FRAME_LEN      = 512;
  localparam int SAMPLE_W       = 16;
  localparam int BITS_PER_FRAME = 2 * SAMPLE_W;
  localparam int CNT_W          = $clog2(FRAME_LEN);

  // Load happens on the edge leaving this count: start of bit period 1.
  localparam logic [CNT_W-1:0] LOAD_CNT = 9'd15;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = CNT_W - 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_pair_t;

  // True on the edge where sck is about to fall (cnt[3:0] wraps 15 -> 0).
  function automatic logic sck_fall_edge(input logic [CNT_W-1:0] cnt);
    return &cnt[SCK_BIT:0];
  endfunction

endpackage

// File: rtl/i2s_frame_tx_if.sv
// rtl/i2s_frame_tx_if.sv - sample pair valid/ready handshake into the I2S transmitter
interface i2s_frame_tx_if;
  import i2s_frame_tx_pkg::*;

  logic [SAMPLE_W-1:0] audio_in_left;
  logic [SAMPLE_W-1:0] audio_in_right;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output audio_in_left,
    output audio_in_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  audio_in_left,
    input  audio_in_right,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_sample_buf.sv
// rtl/i2s_sample_buf.sv - single-entry holding register with replay of the last transmitted pair
module i2s_sample_buf
  import i2s_frame_tx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  i2s_frame_tx_if.slave smp,
  input  logic         load,
  output sample_pair_t frame_data,
  output logic         starved
);

  sample_pair_t hold_q;
  sample_pair_t last_frame_q;
  logic         hold_full_q;
  logic         accept;

  assign smp.sample_ready = !hold_full_q;
  assign accept           = smp.sample_valid && !hold_full_q;
  assign starved          = !hold_full_q;

  // An empty holding register means the frame repeats what was last sent.
  assign frame_data = hold_full_q ? hold_q : last_frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      last_frame_q <= '0;
      hold_full_q  <= 1'b0;
    end else begin
      // Accept and load are exclusive while full; when empty, a same-edge
      // accept wins so the new pair waits for the following frame.
      if (accept) begin
        hold_q      <= {smp.audio_in_left, smp.audio_in_right};
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
      if (load) begin
        last_frame_q <= frame_data;
      end
    end
  end

endmodule

// File: rtl/i2s_frame_tx.sv
// rtl/i2s_frame_tx.sv - I2S transmitter: frame counter, serial shifter and underrun reporting
module i2s_frame_tx
  import i2s_frame_tx_pkg::*;
#(
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  i2s_frame_tx_if.slave     smp,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic              audio_sdin,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  logic [CNT_W-1:0]          cnt;
  logic [BITS_PER_FRAME-1:0] shift_q;
  logic                      load;
  logic                      shift_en;
  logic                      starved;
  sample_pair_t              frame_data;

  assign load     = (cnt == LOAD_CNT);
  assign shift_en = sck_fall_edge(cnt) && !load;

  i2s_sample_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .smp        (smp),
    .load       (load),
    .frame_data (frame_data),
    .starved    (starved)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shift_q      <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      cnt      <= cnt + 1'b1;
      underrun <= load && starved;
      if (load) begin
        shift_q <= frame_data;
      end else if (shift_en) begin
        shift_q <= {shift_q[BITS_PER_FRAME-2:0], 1'b0};
      end
      if (load && starved && !(&underrun_cnt)) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  // All clocks are taps of the registered counter, so they change glitch-free.
  assign audio_mclk = cnt[MCLK_BIT];
  assign audio_sck  = cnt[SCK_BIT];
  assign audio_lrck = cnt[LRCK_BIT];
  assign audio_sdin = shift_q[BITS_PER_FRAME-1];

endmodule
